// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the iterative 32-point FFT controller.
// The scheduler FSM state type lives here so the RTL and any bench see one definition.
package fft_ctrl_pkg;

  localparam int FFT_N    = 32;
  localparam int N_STAGES = 5;
  localparam int STAGE_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } sched_state_t;

endpackage

// File: rtl/fft_wait_timer.sv
// Clear/enable cycle counter that flags its terminal count at TIMEOUT-1.
// It bounds how long the scheduler waits for the level datapath to answer.
module fft_wait_timer #(
  parameter int TIMEOUT = 31,
  parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/fft_level_scheduler.sv
// Time-shares one radix-2 level datapath across all stages of a 32-point FFT:
// issues each level, waits for its result, feeds it back, and hands off the frame.
module fft_level_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int TIMEOUT  = 31,
  parameter int CNT_W    = 16
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               load_en,
  output logic               src_sel,
  output logic               lvl_valid,
  output logic [STAGE_W-1:0] lvl_stage,
  input  logic               lvl_o_valid,
  output logic               cap_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_timeout,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   frame_cnt
);

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic [STAGE_W-1:0] r_stage;
  logic               r_src_sel;
  logic               r_err;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic w_stage_clr;
  logic w_stage_inc;
  logic w_err_set;
  logic w_err_clr;
  logic w_done_hs;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_tc;
  logic w_last_stage;

  assign w_last_stage = (r_stage == STAGE_W'(N_STAGES - 1));

  fft_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk_100MHz),
    .rst  (rst),
    .i_clr(w_tmr_clr),
    .i_en (w_tmr_en),
    .o_tc (w_tmr_tc)
  );

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A result arriving on the terminal timer cycle still counts as success.
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    load_en     = 1'b0;
    lvl_valid   = 1'b0;
    cap_en      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_stage_clr = 1'b0;
    w_stage_inc = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_done_hs   = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load_en     = 1'b1;
          w_stage_clr = 1'b1;
          w_next      = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        lvl_valid = 1'b1;
        w_tmr_clr = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        busy     = 1'b1;
        w_tmr_en = 1'b1;
        if (lvl_o_valid) begin
          cap_en = 1'b1;
          if (w_last_stage) begin
            w_next = DONE;
          end else begin
            w_stage_inc = 1'b1;
            w_next      = ISSUE;
          end
        end else if (w_tmr_tc) begin
          w_err_set = 1'b1;
          w_next    = ERR;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_done_hs   = 1'b1;
          w_stage_clr = 1'b1;
          w_next      = IDLE;
        end
      end
      ERR: begin
        if (err_clr) begin
          w_err_clr   = 1'b1;
          w_stage_clr = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage index and source select change together so both stay stable ISSUE..WAIT.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_stage   <= '0;
      r_src_sel <= 1'b0;
    end else if (w_stage_clr) begin
      r_stage   <= '0;
      r_src_sel <= 1'b0;
    end else if (w_stage_inc) begin
      r_stage   <= r_stage + 1'b1;
      r_src_sel <= 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
      if (w_done_hs) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign lvl_stage   = r_stage;
  assign src_sel     = r_src_sel;
  assign err_timeout = r_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_fft_level_scheduler.sv
// Scoreboard bench for fft_level_scheduler: stimulus queues expected controller
// events, a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_fft_level_scheduler;

  localparam int CNT_W   = 16;
  localparam int EV_LOAD = 0;
  localparam int EV_LVL  = 1;
  localparam int EV_CAP  = 2;
  localparam int EV_OUT  = 3;
  localparam int EV_ERR  = 4;

  logic             clk_100MHz = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             load_en;
  logic             src_sel;
  logic             lvl_valid;
  logic [2:0]       lvl_stage;
  logic             lvl_o_valid;
  logic             cap_en;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             err_timeout;
  logic             err_clr;
  logic [CNT_W-1:0] frame_cnt;

  logic resp = 1'b0;
  logic spur = 1'b0;
  assign lvl_o_valid = resp | spur;

  typedef struct {
    int kind;
    int rel;
    int stage;
    int src;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  lat_cfg[5];
  int  rel_cyc  = 0;
  int  resp_cnt = -1;
  logic prev_out = 1'b0;
  logic prev_err = 1'b0;

  fft_level_scheduler #(
    .N_STAGES(5),
    .TIMEOUT (31),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .src_sel    (src_sel),
    .lvl_valid  (lvl_valid),
    .lvl_stage  (lvl_stage),
    .lvl_o_valid(lvl_o_valid),
    .cap_en     (cap_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Level datapath model: answers lat_cfg[stage] cycles after lvl_valid, never if negative.
  always @(posedge clk_100MHz) begin
    #1;
    resp = 1'b0;
    if (rst) begin
      resp_cnt = -1;
    end else if (lvl_valid) begin
      resp_cnt = lat_cfg[lvl_stage];
    end else if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        resp     = 1'b1;
        resp_cnt = -1;
      end
    end
  end

  // Monitor: one controller event per cycle at most, timed relative to the accept cycle.
  always @(negedge clk_100MHz) begin : mon
    ev_t got;
    ev_t e;
    bit  have;
    have      = 1'b0;
    if (load_en) rel_cyc = 0;
    else         rel_cyc = rel_cyc + 1;
    got.kind  = -1;
    got.rel   = rel_cyc;
    got.stage = int'(lvl_stage);
    got.src   = int'(src_sel);
    if (load_en)                       begin have = 1'b1; got.kind = EV_LOAD; end
    else if (lvl_valid)                begin have = 1'b1; got.kind = EV_LVL;  end
    else if (cap_en)                   begin have = 1'b1; got.kind = EV_CAP;  end
    else if (out_valid && !prev_out)   begin have = 1'b1; got.kind = EV_OUT;  end
    else if (err_timeout && !prev_err) begin have = 1'b1; got.kind = EV_ERR;  end
    prev_out = out_valid;
    prev_err = err_timeout;
    if (have) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: actual kind=%0d rel=%0d stage=%0d src=%0d required none",
                 got.kind, got.rel, got.stage, got.src);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != got.kind || (e.rel >= 0 && e.rel != got.rel) ||
            (e.stage >= 0 && e.stage != got.stage) || (e.src >= 0 && e.src != got.src)) begin
          n_fail++;
          $display("FAIL event: actual kind=%0d rel=%0d stage=%0d src=%0d required kind=%0d rel=%0d stage=%0d src=%0d",
                   got.kind, got.rel, got.stage, got.src, e.kind, e.rel, e.stage, e.src);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic push(input int kind, input int rel, input int stage, input int src);
    ev_t e;
    e.kind  = kind;
    e.rel   = rel;
    e.stage = stage;
    e.src   = src;
    exp_q.push_back(e);
  endtask

  // Expected event sequence for one frame given the per-stage latencies in lat_cfg.
  task automatic expect_frame();
    int c;
    c = 1;
    push(EV_LOAD, 0, -1, -1);
    for (int s = 0; s < 5; s++) begin
      push(EV_LVL, c, s, int'(s != 0));
      if (lat_cfg[s] < 0) begin
        push(EV_ERR, c + 32, -1, -1);
        return;
      end
      push(EV_CAP, c + lat_cfg[s], s, int'(s != 0));
      c = c + lat_cfg[s] + 1;
    end
    push(EV_OUT, c, -1, -1);
  endtask

  task automatic start_frame();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    @(negedge clk_100MHz);
    while (!out_valid && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3, input int l4);
    lat_cfg[0] = l0; lat_cfg[1] = l1; lat_cfg[2] = l2; lat_cfg[3] = l3; lat_cfg[4] = l4;
  endtask

  int t1 [12][4] = '{
    '{EV_LOAD,  0, -1, -1},
    '{EV_LVL,   1,  0,  0}, '{EV_CAP,  4, 0, 0},
    '{EV_LVL,   5,  1,  1}, '{EV_CAP,  8, 1, 1},
    '{EV_LVL,   9,  2,  1}, '{EV_CAP, 12, 2, 1},
    '{EV_LVL,  13,  3,  1}, '{EV_CAP, 16, 3, 1},
    '{EV_LVL,  17,  4,  1}, '{EV_CAP, 20, 4, 1},
    '{EV_OUT,  21, -1, -1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    set_lat(3, 3, 3, 3, 3);

    // Reset state, with in_valid high to show in_ready is forced low.
    #12;
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_load_en",   32'(load_en), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_lvl_stage", 32'(lvl_stage), 32'd0);
    chk("rst_err",       32'(err_timeout), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk_100MHz);
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc();
    @(negedge clk_100MHz);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Test 1: L=3 frame with hand-computed event timeline.
    cyc();
    for (int i = 0; i < 12; i++) push(t1[i][0], t1[i][1], t1[i][2], t1[i][3]);
    start_frame();
    wait_out(40);
    cyc();
    @(negedge clk_100MHz);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_out_valid_low", 32'(out_valid), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // Test 2: backpressure in DONE.
    cyc();
    set_lat(2, 2, 2, 2, 2);
    out_ready = 1'b0;
    expect_frame();
    start_frame();
    wait_out(60);
    for (int i = 0; i < 10; i++) begin
      chk("t2_out_valid_held", 32'(out_valid), 32'd1);
      chk("t2_in_ready_low",   32'(in_ready), 32'd0);
      chk("t2_frame_cnt_hold", 32'(frame_cnt), 32'd1);
      if (i < 9) @(negedge clk_100MHz);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk_100MHz);
    chk("t2_hs_out_valid", 32'(out_valid), 32'd1);
    chk("t2_hs_frame_cnt", 32'(frame_cnt), 32'd1);
    cyc();
    @(negedge clk_100MHz);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("t2_in_ready",  32'(in_ready), 32'd1);

    // Test 3: stage 2 never answers.
    cyc();
    set_lat(2, 2, -1, 2, 2);
    expect_frame();
    start_frame();
    n = 0;
    @(negedge clk_100MHz);
    while (!err_timeout && n < 100) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("t3_err_timeout", 32'(err_timeout), 32'd1);
    chk("t3_in_ready",    32'(in_ready), 32'd0);
    chk("t3_busy",        32'(busy), 32'd0);
    cyc();
    in_valid = 1'b1;
    @(negedge clk_100MHz);
    chk("t3_err_in_ready", 32'(in_ready), 32'd0);
    chk("t3_err_lvl_valid", 32'(lvl_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    err_clr  = 1'b1;
    @(negedge clk_100MHz);
    chk("t3_err_sticky", 32'(err_timeout), 32'd1);
    cyc();
    err_clr = 1'b0;
    @(negedge clk_100MHz);
    chk("t3_clr_in_ready", 32'(in_ready), 32'd1);
    chk("t3_clr_stage",    32'(lvl_stage), 32'd0);
    chk("t3_clr_err",      32'(err_timeout), 32'd0);
    chk("t3_frame_cnt",    32'(frame_cnt), 32'd2);
    cyc();
    err_clr = 1'b1;
    @(negedge clk_100MHz);
    chk("t3_clr_idle_ignored", 32'(in_ready), 32'd1);
    cyc();
    err_clr = 1'b0;

    // Test 4: answer on the last WAIT cycle of stage 0.
    set_lat(31, 2, 2, 2, 2);
    expect_frame();
    start_frame();
    wait_out(200);
    chk("t4_no_err", 32'(err_timeout), 32'd0);
    cyc();
    @(negedge clk_100MHz);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);

    // Test 5: spurious lvl_o_valid in IDLE/DONE, in_valid held through the frame.
    cyc();
    spur = 1'b1;
    @(negedge clk_100MHz);
    chk("t5_idle_cap_en", 32'(cap_en), 32'd0);
    cyc();
    spur = 1'b0;
    set_lat(3, 3, 3, 3, 3);
    out_ready = 1'b0;
    expect_frame();
    in_valid = 1'b1;
    wait_out(60);
    cyc();
    spur = 1'b1;
    @(negedge clk_100MHz);
    chk("t5_done_cap_en", 32'(cap_en), 32'd0);
    chk("t5_done_in_ready", 32'(in_ready), 32'd0);
    cyc();
    spur      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk_100MHz);
    chk("t5_hs_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk_100MHz);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("t5_busy", 32'(busy), 32'd0);

    // Test 6: asynchronous reset in WAIT of stage 3.
    cyc();
    expect_frame();
    start_frame();
    n = 0;
    @(negedge clk_100MHz);
    while (!(lvl_valid && lvl_stage == 3'd3) && n < 40) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("t6_reach_stage3", 32'(lvl_stage), 32'd3);
    @(posedge clk_100MHz);
    #3;
    chk("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_in_ready",  32'(in_ready), 32'd0);
    chk("t6_busy",      32'(busy), 32'd0);
    chk("t6_lvl_stage", 32'(lvl_stage), 32'd0);
    chk("t6_src_sel",   32'(src_sel), 32'd0);
    chk("t6_lvl_valid", 32'(lvl_valid), 32'd0);
    chk("t6_cap_en",    32'(cap_en), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    cyc();
    cyc();
    @(negedge clk_100MHz);
    rst = 1'b0;
    cyc();
    @(negedge clk_100MHz);
    chk("t6_post_in_ready",  32'(in_ready), 32'd1);
    chk("t6_post_frame_cnt", 32'(frame_cnt), 32'd0);
    cyc();
    expect_frame();
    start_frame();
    wait_out(40);
    cyc();
    @(negedge clk_100MHz);
    chk("t6_frame_cnt_after", 32'(frame_cnt), 32'd1);

    for (int i = 0; i < 4; i++) cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
